gray_to_binary_checker: RTL and testbench

Registered Gray-to-binary decoder with step-integrity checking, the receive-side counterpart of the team's registered binary-to-Gray converter. It accepts Gray-coded samples (e.g. a Gray pointer or position counter crossing into this domain), decodes them to binary through a two-stage pipeline, and flags any accepted sample that differs from the previous accepted sample in more than one bit. A saturating error counter accumulates violations for status readout.

---
 rtl/gray_to_binary_checker_if.sv | 23 ++
 rtl/gray_to_binary_checker.sv | 105 ++++++++++
 tb/tb_gray_to_binary_checker.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/gray_to_binary_checker_if.sv
// Sample/status bundle for the registered Gray-to-binary decoder with step checking.
// The master side drives Gray samples and the error-clear; the slave side returns decoded results.
interface gray_to_binary_checker_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] gray_in;
    logic             err_clr;
    logic             out_valid;
    logic [WIDTH-1:0] binary_out;
    logic             step_err;
    logic [7:0]       err_count;

    modport master (
        output in_valid, gray_in, err_clr,
        input  out_valid, binary_out, step_err, err_count
    );

    modport slave (
        input  in_valid, gray_in, err_clr,
        output out_valid, binary_out, step_err, err_count
    );
endinterface

// File: rtl/gray_to_binary_checker.sv
// Two-stage registered Gray-to-binary decoder with single-bit-step integrity checking.
// Define GRAY_DEC_STEP_CHECK_EN to build the step checker and saturating error counter.
module gray_to_binary_checker #(
    parameter int WIDTH = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    gray_to_binary_checker_if.slave bus
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_gray;
    logic [WIDTH-1:0] dec_bin;
    logic             out_valid_q;
    logic [WIDTH-1:0] binary_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_gray  <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_gray <= bus.gray_in;
            end
        end
    end

    // Binary bit i is the parity of Gray bits i and above.
    always_comb begin
        dec_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec_bin[i] = ^(s1_gray >> i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            binary_q    <= '0;
        end else begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                binary_q <= dec_bin;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.binary_out = binary_q;

`ifdef GRAY_DEC_STEP_CHECK_EN
    typedef enum logic {
        IDLE,
        TRACK
    } check_state_t;

    check_state_t     state;
    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] diff;
    logic             multi_bit;
    logic             step_err_q;
    logic [7:0]       err_count_q;

    // Clearing the lowest set bit leaves something only if two or more bits differ.
    assign diff      = s1_gray ^ prev_gray;
    assign multi_bit = (diff & (diff - WIDTH'(1))) != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev_gray  <= '0;
            step_err_q <= 1'b0;
        end else begin
            step_err_q <= 1'b0;
            if (s1_valid) begin
                prev_gray <= s1_gray;
                case (state)
                    IDLE:    state      <= TRACK;
                    TRACK:   step_err_q <= multi_bit;
                    default: state      <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else if (bus.err_clr) begin
            err_count_q <= '0;
        end else if (step_err_q && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign bus.step_err  = step_err_q;
    assign bus.err_count = err_count_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = bus.err_clr;
    assign bus.step_err   = 1'b0;
    assign bus.err_count  = '0;
`endif
endmodule

// File: tb/tb_gray_to_binary_checker.sv
// Self-checking bench for gray_to_binary_checker: directed vector tables, corner sequences
// and randomized traffic against an input-history reference model.
module tb_gray_to_binary_checker;
`ifdef GRAY_DEC_STEP_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    gray_to_binary_checker_if #(.WIDTH(4)) bus ();

    gray_to_binary_checker #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the last captured input plus the expected visible outputs.
    bit         hv_valid;
    logic [3:0] hv_gray;
    bit         have_prev;
    logic [3:0] prev_g;
    bit         exp_ov;
    logic [3:0] exp_bin;
    bit         exp_err;
    int         exp_cnt;

    typedef struct {
        bit         seg_start;
        logic [3:0] gray;
        logic [3:0] exp_bin;
        bit         exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [3:0] gray_decode(input logic [3:0] g);
        logic [3:0] b;
        b = g;
        for (int s = 1; s < 4; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic compare(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hv_valid  = 1'b0;
        hv_gray   = '0;
        have_prev = 1'b0;
        prev_g    = '0;
        exp_ov    = 1'b0;
        exp_bin   = '0;
        exp_err   = 1'b0;
        exp_cnt   = 0;
    endtask

    task automatic check_output();
        compare("out_valid", int'(bus.out_valid), int'(exp_ov));
        compare("binary_out", int'(bus.binary_out), int'(exp_bin));
        compare("step_err", int'(bus.step_err), int'(exp_err));
        compare("err_count", int'(bus.err_count), exp_cnt);
    endtask

    // One clock cycle: drive inputs, advance the model across the edge, check #1 later.
    task automatic apply_stimulus(input bit r_n, input bit v, input logic [3:0] g, input bit clr);
        rst_n        = r_n;
        bus.in_valid = v;
        bus.gray_in  = g;
        bus.err_clr  = clr;
        @(posedge clk);
        if (!r_n) begin
            model_reset();
        end else begin
            if (clr) exp_cnt = 0;
            else if (exp_err && exp_cnt < 255) exp_cnt++;
            if (hv_valid) begin
                exp_ov    = 1'b1;
                exp_bin   = gray_decode(hv_gray);
                exp_err   = CHK_EN && have_prev && ($countones(hv_gray ^ prev_g) > 1);
                prev_g    = hv_gray;
                have_prev = 1'b1;
            end else begin
                exp_ov  = 1'b0;
                exp_err = 1'b0;
            end
            hv_valid = v;
            hv_gray  = g;
        end
        #1;
        check_output();
    endtask

    initial begin
        int         pend;
        logic [3:0] g;
        logic [3:0] last_g;
        logic [3:0] sweep[16];

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.gray_in  = '0;
        bus.err_clr  = 1'b0;
        model_reset();

        // Reset held with valid traffic on the inputs: everything stays zero.
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 4'hF, 1'b0);
        compare("reset_out_valid", int'(bus.out_valid), 0);
        compare("reset_err_count", int'(bus.err_count), 0);

        sweep = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        for (int i = 0; i < 16; i++)
            tbl.push_back('{(i == 0), sweep[i], 4'(i), 1'b0});
        tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 4'hA, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 4'hA, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{1'b0, 4'h3, 4'h2, 1'b1});
        tbl.push_back('{1'b0, 4'h2, 4'h3, 1'b0});

        pend = -1;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].seg_start) begin
                apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
                if (pend >= 0) begin
                    compare("tbl_bin", int'(bus.binary_out), int'(tbl[pend].exp_bin));
                    compare("tbl_err", int'(bus.step_err), int'(CHK_EN && tbl[pend].exp_err));
                end
                apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
                apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0);
                pend = -1;
            end
            apply_stimulus(1'b1, 1'b1, tbl[i].gray, 1'b0);
            if (pend >= 0) begin
                compare("tbl_bin", int'(bus.binary_out), int'(tbl[pend].exp_bin));
                compare("tbl_err", int'(bus.step_err), int'(CHK_EN && tbl[pend].exp_err));
            end
            pend = i;
        end
        apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
        compare("tbl_bin", int'(bus.binary_out), int'(tbl[pend].exp_bin));
        compare("tbl_err", int'(bus.step_err), int'(CHK_EN && tbl[pend].exp_err));
        apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
        compare("viol_count", int'(bus.err_count), CHK_EN ? 1 : 0);

        // Saturation: alternating two-bit steps, then clear on an increment cycle.
        for (int i = 0; i < 300; i++)
            apply_stimulus(1'b1, 1'b1, (i % 2 == 0) ? 4'h0 : 4'h3, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'h0, 1'b0);
        compare("sat_count", int'(bus.err_count), CHK_EN ? 255 : 0);
        compare("sat_step_err", int'(bus.step_err), int'(CHK_EN));
        apply_stimulus(1'b1, 1'b1, 4'h3, 1'b1);
        compare("clr_count", int'(bus.err_count), 0);
        apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);

        // Mid-stream reset kills in-flight samples; next sample is unchecked.
        apply_stimulus(1'b1, 1'b1, 4'h5, 1'b0);
        apply_stimulus(1'b0, 1'b1, 4'h4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
            compare("flush_out_valid", int'(bus.out_valid), 0);
        end
        apply_stimulus(1'b1, 1'b1, 4'hC, 1'b0);
        apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
        compare("post_rst_valid", int'(bus.out_valid), 1);
        compare("post_rst_bin", int'(bus.binary_out), 8);
        compare("post_rst_err", int'(bus.step_err), 0);

        // Randomized traffic: mostly legal steps, some jumps, clears and resets.
        last_g = 4'h0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) < 70) g = last_g ^ (4'b0001 << $urandom_range(3));
            else if ($urandom_range(1) == 0) g = last_g;
            else g = 4'($urandom);
            if ($urandom_range(99) < 80) last_g = g;
            apply_stimulus(($urandom_range(99) != 0), ($urandom_range(99) < 80), g,
                           ($urandom_range(99) < 5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
